// File: rtl/usbf_crc16_chk_pkg.sv
// rtl/usbf_crc16_chk_pkg.sv - shared CRC16 constants and FSM encodings for the USB receive CRC16 checker
`ifndef USBF_DEFINES_V
`define USBF_DEFINES_V
`define USBF_CRC16_INIT     16'hffff
`define USBF_CRC16_RESIDUAL 16'h800d
`endif

package usbf_crc16_chk_pkg;

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_DATA    = 1'b1;
    localparam logic [15:0] CRC16_POLY = 16'h8005;

endpackage

// File: rtl/usbf_crc16.sv
// rtl/usbf_crc16.sv - combinational USB CRC16 next-state term, one byte shifted in LSB first
module usbf_crc16
    import usbf_crc16_chk_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
        crc_out = c;
    end

endmodule

// File: rtl/usbf_crc16_chk.sv
// rtl/usbf_crc16_chk.sv - USB DATA packet receive CRC16 checker with two-byte CRC hold-back
// Optional payload length limit enabled by defining USBF_CRC16_CHK_MAXLEN_EN.
module usbf_crc16_chk
    import usbf_crc16_chk_pkg::*;
#(
    parameter int MAX_PL = 1023,
    parameter int CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_start,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             pkt_end,
    output logic [7:0]       dout,
    output logic             dout_valid,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             short_err,
    output logic             ovf_err,
    output logic [CNT_W-1:0] payload_len
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]       state;
    logic [15:0]      crc_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       hc;
    logic [7:0]       h0;
    logic [7:0]       h1;
    logic             clr_pend;

    logic             closing;
    logic             fresh;
    logic             accept;
    logic [15:0]      crc_base;
    logic [15:0]      crc_upd;
    logic [15:0]      crc_nx;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_nx;
    logic [1:0]       hc_base;
    logic [1:0]       hc_nx;
    logic             short_nx;
    logic             res_ok;
    logic             over_nx;
    logic             ovf_nx;
    logic             fwd;

    usbf_crc16 u_crc16 (
        .crc_in  (crc_base),
        .data    (din),
        .crc_out (crc_upd)
    );

    // A byte arriving with pkt_end belongs to the closing packet, even if pkt_start coincides.
    always_comb begin
        closing  = pkt_end && (state == ST_DATA);
        fresh    = pkt_start && !closing;
        accept   = din_valid && ((state == ST_DATA) || pkt_start);
        crc_base = fresh ? `USBF_CRC16_INIT : crc_q;
        cnt_base = fresh ? '0 : cnt;
        hc_base  = fresh ? 2'd0 : hc;
        crc_nx   = crc_base;
        cnt_nx   = cnt_base;
        hc_nx    = hc_base;
        if (accept) begin
            crc_nx = crc_upd;
            if (cnt_base != CNT_MAX) begin
                cnt_nx = cnt_base + CNT_W'(1);
            end
            if (hc_base != 2'd2) begin
                hc_nx = hc_base + 2'd1;
            end
        end
        short_nx = (hc_nx != 2'd2);
        res_ok   = (crc_nx == `USBF_CRC16_RESIDUAL);
`ifdef USBF_CRC16_CHK_MAXLEN_EN
        over_nx  = (cnt_nx > CNT_W'(MAX_PL + 2));
`else
        over_nx  = 1'b0;
`endif
        ovf_nx   = !short_nx && over_nx;
        fwd      = accept && (hc_base == 2'd2) && !over_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            crc_q       <= `USBF_CRC16_INIT;
            cnt         <= '0;
            hc          <= 2'd0;
            h0          <= 8'h00;
            h1          <= 8'h00;
            clr_pend    <= 1'b0;
            dout        <= 8'h00;
            dout_valid  <= 1'b0;
            done        <= 1'b0;
            crc_ok      <= 1'b0;
            crc_err     <= 1'b0;
            short_err   <= 1'b0;
            payload_len <= '0;
        end else begin
            if (pkt_start) begin
                state <= ST_DATA;
            end else if (closing) begin
                state <= ST_IDLE;
            end

            if (closing) begin
                crc_q <= `USBF_CRC16_INIT;
                cnt   <= '0;
                hc    <= 2'd0;
            end else begin
                crc_q <= crc_nx;
                cnt   <= cnt_nx;
                hc    <= hc_nx;
            end

            if (accept) begin
                h1 <= h0;
                h0 <= din;
            end
            dout_valid <= fwd;
            if (fwd) begin
                dout <= h1;
            end

            done     <= closing;
            clr_pend <= closing && pkt_start;

            // Status of a packet closed together with a new start stays visible for the done cycle.
            if (closing) begin
                crc_ok      <= !short_nx && res_ok && !ovf_nx;
                crc_err     <= !short_nx && !res_ok;
                short_err   <= short_nx;
                payload_len <= short_nx ? '0 : cnt_nx - CNT_W'(2);
            end else if (pkt_start || clr_pend) begin
                crc_ok      <= 1'b0;
                crc_err     <= 1'b0;
                short_err   <= 1'b0;
                payload_len <= '0;
            end
        end
    end

`ifdef USBF_CRC16_CHK_MAXLEN_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (closing) begin
            ovf_q <= ovf_nx;
        end else if (pkt_start || clr_pend) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf_err = ovf_q;
`else
    logic unused_max_pl;

    assign unused_max_pl = (MAX_PL > 0) ^ ovf_nx;
    assign ovf_err       = 1'b0;
`endif

endmodule

// File: tb/tb_usbf_crc16_chk.sv
// tb/tb_usbf_crc16_chk.sv - self-checking bench for usbf_crc16_chk against a packet-level model
module tb_usbf_crc16_chk;

    localparam int MAX_PL = 4;
    localparam int CNT_W  = 11;
`ifdef USBF_CRC16_CHK_MAXLEN_EN
    localparam int LIM = MAX_PL + 2;
`else
    localparam int LIM = 1 << 30;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pkt_start = 1'b0;
    logic [7:0]       din = 8'h00;
    logic             din_valid = 1'b0;
    logic             pkt_end = 1'b0;
    logic [7:0]       dout;
    logic             dout_valid;
    logic             done;
    logic             crc_ok;
    logic             crc_err;
    logic             short_err;
    logic             ovf_err;
    logic [CNT_W-1:0] payload_len;

    always #5 clk = ~clk;

    usbf_crc16_chk #(.MAX_PL(MAX_PL), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .pkt_start   (pkt_start),
        .din         (din),
        .din_valid   (din_valid),
        .pkt_end     (pkt_end),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .done        (done),
        .crc_ok      (crc_ok),
        .crc_err     (crc_err),
        .short_err   (short_err),
        .ovf_err     (ovf_err),
        .payload_len (payload_len)
    );

    int vectors     = 0;
    int miscompares = 0;
    int dv_seen     = 0;
    int done_seen   = 0;

    // Packet-level model: the bytes of the open packet and the outputs expected after each edge.
    byte_q_t    mq;
    bit         m_in_pkt   = 0;
    bit         m_clr_pend = 0;
    logic       exp_dv     = 1'b0;
    logic [7:0] exp_dout   = 8'h00;
    logic       exp_done   = 1'b0;
    logic       exp_ok     = 1'b0;
    logic       exp_err    = 1'b0;
    logic       exp_short  = 1'b0;
    logic       exp_ovf    = 1'b0;
    int         exp_len    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reflected CRC-16/USB register (poly 0xA001, init 0xFFFF), no final inversion.
    function automatic logic [15:0] crc_reg(input byte_q_t q);
        logic [15:0] r = 16'hffff;
        foreach (q[i]) begin
            r = r ^ {8'h00, q[i]};
            for (int b = 0; b < 8; b++) begin
                r = r[0] ? ((r >> 1) ^ 16'ha001) : (r >> 1);
            end
        end
        return r;
    endfunction

    function automatic byte_q_t with_crc(input byte_q_t q);
        byte_q_t     o = q;
        logic [15:0] c = ~crc_reg(q);
        o.push_back(c[7:0]);
        o.push_back(c[15:8]);
        return o;
    endfunction

    function automatic byte_q_t seq(input int n, input logic [7:0] first);
        byte_q_t o;
        for (int i = 0; i < n; i++) o.push_back(first + 8'(i));
        return o;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_in_pkt   = 0;
        m_clr_pend = 0;
        exp_dv     = 1'b0;
        exp_dout   = 8'h00;
        exp_done   = 1'b0;
        exp_ok     = 1'b0;
        exp_err    = 1'b0;
        exp_short  = 1'b0;
        exp_ovf    = 1'b0;
        exp_len    = 0;
    endtask

    task automatic step(input logic s, input logic e, input logic v, input logic [7:0] d);
        int n;
        bit closing;
        bit res;
        pkt_start = s;
        pkt_end   = e;
        din_valid = v;
        din       = d;
        @(posedge clk);
        closing  = e && m_in_pkt;
        exp_dv   = 1'b0;
        exp_done = 1'b0;
        if (s && !closing) begin
            mq.delete();
            m_in_pkt = 1;
        end
        if (!closing && (s || m_clr_pend)) begin
            exp_ok = 0; exp_err = 0; exp_short = 0; exp_ovf = 0; exp_len = 0;
        end
        m_clr_pend = closing && s;
        if (v && m_in_pkt) begin
            mq.push_back(d);
            n = mq.size();
            if (n >= 3 && n <= LIM) begin
                exp_dv   = 1'b1;
                exp_dout = mq[n-3];
            end
        end
        if (closing) begin
            exp_done = 1'b1;
            n = mq.size();
            if (n < 2) begin
                exp_short = 1; exp_ok = 0; exp_err = 0; exp_ovf = 0; exp_len = 0;
            end else begin
                res       = (crc_reg(mq) == 16'hb001);
                exp_short = 0;
                exp_ovf   = (n - 2 > MAX_PL) && (LIM == MAX_PL + 2);
                exp_ok    = res && !exp_ovf;
                exp_err   = !res;
                exp_len   = n - 2;
            end
            mq.delete();
            m_in_pkt = s;
        end
        #1;
    endtask

    task automatic send(input byte_q_t q, input bit end_with_last);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        foreach (q[i]) step(1'b0, end_with_last && (i == q.size() - 1), 1'b1, q[i]);
        if (!end_with_last) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    always @(negedge clk) begin
        check("dout_valid", dout_valid, exp_dv);
        if (exp_dv || !rst) check("dout", dout, exp_dout);
        check("done", done, exp_done);
        check("crc_ok", crc_ok, exp_ok);
        check("crc_err", crc_err, exp_err);
        check("short_err", short_err, exp_short);
        check("ovf_err", ovf_err, exp_ovf);
        check("payload_len", payload_len, exp_len);
        if (dout_valid === 1'b1) dv_seen++;
        if (done === 1'b1) done_seen++;
    end

    byte_q_t     p, q;
    logic [15:0] pin;
    int          dv0, dn0;

    initial begin
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_dout_valid", dout_valid, 1'b0);
        check("reset_payload_len", payload_len, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);

        p   = seq(9, 8'h31);
        pin = ~crc_reg(p);
        check("pin_crc_123456789", pin, 16'hb4c8);
        p.delete();
        p.push_back(8'h00);
        p.push_back(8'h00);
        check("pin_zlp_residual", crc_reg(p), 16'hb001);
        p.delete();
        q = with_crc(p);
        check("pin_zlp_crc_bytes", {q[0], q[1]}, 16'h0000);

        dv0 = dv_seen; dn0 = done_seen;
        step(1'b0, 1'b1, 1'b1, 8'h33);
        step(1'b0, 1'b0, 0, 8'h00);
        check("idle_ignored_done", done_seen - dn0, 0);
        check("idle_ignored_dv", dv_seen - dv0, 0);

        dv0 = dv_seen; dn0 = done_seen;
        send(with_crc(p), 1'b1);
        check("zlp_dv", dv_seen - dv0, 0);
        check("zlp_done", done_seen - dn0, 1);
        check("zlp_ok", crc_ok, 1'b1);
        check("zlp_len", payload_len, 0);

        p = seq(4, 8'h00);
        q = with_crc(p);
        dv0 = dv_seen;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, q[0]);
        step(1'b0, 1'b0, 1'b1, q[1]);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 2; i < 6; i++) step(1'b0, 1'b0, 1'b1, q[i]);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("p4_dv", dv_seen - dv0, 4);
        check("p4_ok", crc_ok, 1'b1);
        check("p4_err", crc_err, 1'b0);
        check("p4_len", payload_len, 4);

        q[5] = q[5] ^ 8'h01;
        dv0 = dv_seen;
        send(q, 1'b0);
        check("bad_dv", dv_seen - dv0, 4);
        check("bad_err", crc_err, 1'b1);
        check("bad_ok", crc_ok, 1'b0);

        p.delete();
        p.push_back(8'ha5);
        dv0 = dv_seen;
        send(p, 1'b1);
        check("short_flag", short_err, 1'b1);
        check("short_dv", dv_seen - dv0, 0);
        check("short_len", payload_len, 0);

        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h10 + 8'(i));
        rst = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_mid_dv", dout_valid, 1'b0);
        check("rst_mid_short", short_err, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        dv0 = dv_seen;
        send(with_crc(seq(4, 8'h00)), 1'b0);
        check("after_rst_dv", dv_seen - dv0, 4);
        check("after_rst_ok", crc_ok, 1'b1);

        p.delete();
        p.push_back(8'hde);
        p.push_back(8'had);
        q = with_crc(p);
        dv0 = dv_seen; dn0 = done_seen;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b0, 1'b1, 8'h66);
        step(1'b0, 1'b0, 1'b1, 8'h77);
        step(1'b1, 1'b0, 1'b1, q[0]);
        for (int i = 1; i < 4; i++) step(1'b0, i == 3, 1'b1, q[i]);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("abort_done", done_seen - dn0, 1);
        check("abort_dv", dv_seen - dv0, 3);
        check("abort_ok", crc_ok, 1'b1);
        check("abort_len", payload_len, 2);

        q = with_crc(seq(4, 8'h00));
        dv0 = dv_seen; dn0 = done_seen;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, q[i]);
        step(1'b1, 1'b1, 1'b1, q[5]);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("se_done", done_seen - dn0, 2);
        check("se_dv", dv_seen - dv0, 4);
        check("se_ok", crc_ok, 1'b1);
        check("se_len", payload_len, 0);

        dv0 = dv_seen;
        send(with_crc(seq(6, 8'h01)), 1'b0);
        check("p6_len", payload_len, 6);
`ifdef USBF_CRC16_CHK_MAXLEN_EN
        check("p6_dv", dv_seen - dv0, 4);
        check("p6_ovf", ovf_err, 1'b1);
        check("p6_ok", crc_ok, 1'b0);
`else
        check("p6_dv", dv_seen - dv0, 6);
        check("p6_ovf", ovf_err, 1'b0);
        check("p6_ok", crc_ok, 1'b1);
`endif

        step(1'b0, 1'b0, 1'b0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
